// File: rtl/bf16_adder_arbiter.sv
// Round-robin front end that time-shares a single bfloat16 adder among NUM_REQ
// requesters, returning each sum tagged with its owner and guarding with a watchdog.
module bf16_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rsp_valid,
    output logic [15:0]            rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   rsp_ready,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    output logic                   add_a_stb,
    output logic                   add_b_stb,
    input  logic [15:0]            add_z,
    input  logic                   add_z_stb,
    output logic                   busy,
    output logic                   err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [15:0]     add_a_q;
    logic [15:0]     add_b_q;
    logic            stb_q;
    logic            rsp_valid_q;
    logic [15:0]     rsp_data_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            err_q;

    logic            gnt_any;
    logic            hi_any;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;
    logic [ID_W-1:0] gnt_idx;
    logic [15:0]     sel_a;
    logic [15:0]     sel_b;

    // Lowest requester above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        gnt_any = 1'b0;
        hi_any  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                lo_idx  = ID_W'(i);
                if (i > int'(last_q)) begin
                    hi_any = 1'b1;
                    hi_idx = ID_W'(i);
                end
            end
        end
        gnt_idx = hi_any ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == IDLE) && gnt_any && (gnt_idx == ID_W'(gi));
    end

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(NUM_REQ - 1);
            tag_q       <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        add_a_q <= sel_a;
                        add_b_q <= sel_b;
                        tag_q   <= gnt_idx;
                        last_q  <= gnt_idx;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    stb_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Strobes drop on the result edge so the adder never re-takes stale operands.
                    if (add_z_stb) begin
                        rsp_data_q  <= add_z;
                        rsp_id_q    <= tag_q;
                        rsp_valid_q <= 1'b1;
                        stb_q       <= 1'b0;
                        state_q     <= RESP;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        stb_q   <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_a_stb = stb_q;
    assign add_b_stb = stb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_bf16_adder_arbiter.sv
// Directed bench for bf16_adder_arbiter with a behavioural adder stand-in and a
// scoreboard of expected (id, sum) pairs pushed at grant and popped at accept.
module tb_bf16_adder_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int TO  = 15;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [16*NR-1:0]  req_a;
    logic [16*NR-1:0]  req_b;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [15:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic [15:0]       add_a;
    logic [15:0]       add_b;
    logic              add_a_stb;
    logic              add_b_stb;
    logic [15:0]       add_z;
    logic              add_z_stb;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    bf16_adder_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
        .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
        .add_z(add_z), .add_z_stb(add_z_stb), .busy(busy), .err(err)
    );

    // Requester i is valid while it has more operations issued than granted.
    int          issued [NR];
    int          granted[NR];
    logic [15:0] op_a   [NR];
    logic [15:0] op_b   [NR];
    logic [15:0] exp_sum[NR];

    for (genvar gi = 0; gi < NR; gi++) begin : g_req
        assign req_valid[gi]       = (issued[gi] > granted[gi]);
        assign req_a[16*gi +: 16]  = op_a[gi];
        assign req_b[16*gi +: 16]  = op_b[gi];
    end

    // Adder stand-in: bf16 sums of the operand pairs used below, LAT cycles after both strobes.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3F80_3F80: return 16'h4000;
            32'h4040_3F80: return 16'h4080;
            32'hBF80_3F80: return 16'h0000;
            32'h4000_4000: return 16'h4080;
            32'h3F80_4000: return 16'h4040;
            32'h4080_4080: return 16'h4100;
            32'h4000_4040: return 16'h40A0;
            32'h3F00_3F00: return 16'h3F80;
            default:       return 16'hFFFF;
        endcase
    endfunction

    logic        stuck;
    logic        m_busy;
    int          m_cnt;
    logic [15:0] m_z;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_z       <= '0;
            add_z     <= '0;
            add_z_stb <= 1'b0;
        end else begin
            add_z_stb <= 1'b0;
            if (!m_busy) begin
                if (add_a_stb && add_b_stb && !add_z_stb && !stuck) begin
                    m_busy <= 1'b1;
                    m_cnt  <= LAT;
                    m_z    <= ref_add(add_a, add_b);
                end
            end else if (m_cnt == 0) begin
                add_z_stb <= 1'b1;
                add_z     <= m_z;
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          gnt_id_q[$];
    int          gnt_cyc_q[$];
    int          acc_cyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_rsp = 0;
    int          cyc = 0;
    int          stb_rise_cyc = -1;
    int          z_cyc = -1;
    int          rsp_rise_cyc = -1;
    int          err_rise_cyc = -1;
    logic [NR-1:0] gnt_pend = '0;
    logic        prev_z = 1'b0;
    logic        prev_rv = 1'b0;
    logic        prev_rr = 1'b0;
    logic        prev_stb = 1'b0;
    logic        prev_err = 1'b0;
    logic [15:0] prev_data = '0;
    logic [IDW-1:0] prev_id = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    // One clock: observe at the falling edge, then apply requester updates just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (req_ready != '0) begin
                chk("gnt_onehot", 32'($onehot(req_ready)), 1);
                chk("gnt_only_idle", busy, 0);
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) begin
                        e.id   = i;
                        e.data = exp_sum[i];
                        sb_q.push_back(e);
                        gnt_id_q.push_back(i);
                        gnt_cyc_q.push_back(cyc);
                        gnt_pend[i] = 1'b1;
                    end
                end
            end
            if (prev_z) chk("stb_low_after_z", {add_a_stb, add_b_stb}, 0);
            if (prev_rv && !prev_rr && rsp_valid) begin
                chk("hold_data", rsp_data, prev_data);
                chk("hold_id", rsp_id, prev_id);
            end
            if (add_a_stb && !prev_stb) stb_rise_cyc = cyc;
            if (add_z_stb) z_cyc = cyc;
            if (rsp_valid && !prev_rv) rsp_rise_cyc = cyc;
            if (err && !prev_err) begin
                err_rise_cyc = cyc;
                if (sb_q.size() > 0) void'(sb_q.pop_front());
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                acc_cyc_q.push_back(cyc);
                $display("rsp cycle=%0d id=%0d data=%h", cyc, rsp_id, rsp_data);
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", n_rsp, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                end
            end
        end
        prev_z    = add_z_stb;
        prev_rv   = rsp_valid;
        prev_rr   = rsp_ready;
        prev_stb  = add_a_stb;
        prev_err  = err;
        prev_data = rsp_data;
        prev_id   = rsp_id;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (gnt_pend[i]) granted[i]++;
        end
        gnt_pend = '0;
    endtask

    task automatic request(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        op_a[i]    = a;
        op_b[i]    = b;
        exp_sum[i] = s;
        issued[i]++;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            tick();
            done = (sb_q.size() == 0) && !busy && !rsp_valid;
            for (int i = 0; i < NR; i++) if (issued[i] != granted[i]) done = 1'b0;
        end
        chk(tag, done, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        acc_cyc_q.delete();
        tick();
    endtask

    int base;
    int exp_order[$];

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        stuck     = 1'b0;
        for (int i = 0; i < NR; i++) begin
            issued[i]  = 0;
            granted[i] = 0;
            op_a[i]    = '0;
            op_b[i]    = '0;
            exp_sum[i] = '0;
        end
        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_data, rsp_id}, 0);
        chk("rst_add", {add_a, add_b, add_a_stb, add_b_stb}, 0);
        chk("rst_busy_err", {busy, err}, 0);
        rst = 1'b0;
        tick();

        // Single request from id 1: latency and strobe shape.
        base = n_rsp;
        request(1, 16'h3F80, 16'h3F80, 16'h4000);
        wait_idle("single_done", 40);
        chk("single_ngnt", gnt_id_q.size(), 1);
        if (gnt_id_q.size() >= 1) begin
            chk("single_gnt_id", gnt_id_q[0], 1);
            chk("single_stb_lat", stb_rise_cyc - gnt_cyc_q[0], 2);
        end
        chk("single_rsp_lat", rsp_rise_cyc - z_cyc, 1);
        chk("single_nrsp", n_rsp - base, 1);

        // All four requesting, requester 0 twice.
        do_reset();
        request(0, 16'h4040, 16'h3F80, 16'h4080);
        request(0, 16'h4040, 16'h3F80, 16'h4080);
        request(1, 16'hBF80, 16'h3F80, 16'h0000);
        request(2, 16'h4000, 16'h4000, 16'h4080);
        request(3, 16'h3F80, 16'h4000, 16'h4040);
        wait_idle("all4_done", 120);
        exp_order = '{0, 1, 2, 3, 0};
        chk("all4_ngnt", gnt_id_q.size(), 5);
        for (int k = 0; k < 5 && k < gnt_id_q.size(); k++) chk("all4_order", gnt_id_q[k], exp_order[k]);

        // Requesters 0 and 2 continuously requesting must alternate.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            request(0, 16'h4080, 16'h4080, 16'h4100);
            request(2, 16'h4000, 16'h4040, 16'h40A0);
        end
        wait_idle("alt_done", 150);
        exp_order = '{0, 2, 0, 2, 0, 2};
        chk("alt_ngnt", gnt_id_q.size(), 6);
        for (int k = 0; k < 6 && k < gnt_id_q.size(); k++) chk("alt_order", gnt_id_q[k], exp_order[k]);

        // Backpressure: response held 20 cycles while requester 3 waits.
        do_reset();
        rsp_ready = 1'b0;
        request(1, 16'h3F00, 16'h3F00, 16'h3F80);
        request(3, 16'h3F80, 16'h3F80, 16'h4000);
        for (int n = 0; n < 40 && !rsp_valid; n++) tick();
        chk("bp_rsp_seen", rsp_valid, 1);
        for (int n = 0; n < 20; n++) tick();
        chk("bp_no_gnt", gnt_id_q.size(), 1);
        chk("bp_valid_held", rsp_valid, 1);
        chk("bp_id_held", rsp_id, 1);
        rsp_ready = 1'b1;
        wait_idle("bp_done", 60);
        if (gnt_cyc_q.size() >= 2 && acc_cyc_q.size() >= 1)
            chk("bp_gnt_after_acc", gnt_cyc_q[1] - acc_cyc_q[0], 1);
        else
            chk("bp_gnt_count", gnt_cyc_q.size(), 2);

        // Watchdog: adder never answers.
        do_reset();
        stuck = 1'b1;
        base = n_rsp;
        err_rise_cyc = -1;
        request(2, 16'h3F80, 16'h4000, 16'h4040);
        for (int n = 0; n < 40 && err_rise_cyc < 0; n++) tick();
        chk("to_err", err, 1);
        if (gnt_cyc_q.size() >= 1) chk("to_err_timing", err_rise_cyc - gnt_cyc_q[0], 17);
        chk("to_idle", {busy, add_a_stb, add_b_stb, rsp_valid}, 0);
        chk("to_no_rsp", n_rsp - base, 0);
        stuck = 1'b0;
        request(2, 16'h3F80, 16'h3F80, 16'h4000);
        wait_idle("to_next_done", 40);
        chk("to_next_nrsp", n_rsp - base, 1);
        chk("to_err_sticky", err, 1);

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        chk("rst_clears_err", err, 0);
        request(0, 16'h4040, 16'h3F80, 16'h4080);
        for (int n = 0; n < 20 && !add_a_stb; n++) tick();
        chk("mid_stb_seen", add_a_stb, 1);
        tick();
        base = n_rsp;
        #2;
        rst = 1'b1;
        #1;
        chk("async_ctl", {req_ready, rsp_valid, add_a_stb, add_b_stb, busy, err}, 0);
        chk("async_data", {add_a, add_b, rsp_data, rsp_id}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        request(3, 16'h4000, 16'h4040, 16'h40A0);
        wait_idle("post_rst_done", 40);
        chk("post_rst_nrsp", n_rsp - base, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
